// File: rtl/debug_report_tx.sv
// debug_report_tx: transmit-side framer of the debug unit.
// On i_start it snapshots PC and cycle count, walks the register file and the
// dirty words of data memory, and streams the report byte-by-byte to the UART
// TX core: HEADER, PC, CYCLES, R0..R31, {addr, data} per dirty word, TRAILER.
// Optional feature macro: REPORT_CHECKSUM_EN inserts an XOR checksum byte
// (all bytes after HEADER up to the last memory byte) just before TRAILER.
module debug_report_tx #(
    parameter int         NB_DATA     = 32,
    parameter int         NB_REG      = 5,
    parameter int         NB_MEM_ADDR = 5,
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter logic [7:0] TRAILER     = 8'h5A
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [NB_DATA-1:0]     i_pc,
    input  logic [NB_DATA-1:0]     i_cycles,
    output logic                   o_reg_rd_en,
    output logic [NB_REG-1:0]      o_addr_reg,
    input  logic [NB_DATA-1:0]     i_reg_data,
    output logic                   o_mem_rd_en,
    output logic [NB_MEM_ADDR-1:0] o_addr_mem,
    input  logic [NB_DATA-1:0]     i_mem_data,
    input  logic                   i_bit_sucio,
    output logic                   o_tx_start,
    output logic [7:0]             o_tx_data,
    input  logic                   i_tx_done,
    output logic                   o_busy,
    output logic                   o_done
);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_HDR      = 4'd1,
        ST_PC       = 4'd2,
        ST_CYC      = 4'd3,
        ST_REG_RD   = 4'd4,
        ST_REG_LAT  = 4'd5,
        ST_REG_SEND = 4'd6,
        ST_MEM_RD   = 4'd7,
        ST_MEM_CHK  = 4'd8,
        ST_MEM_SEND = 4'd9,
        ST_CSUM     = 4'd10,
        ST_TRL      = 4'd11
    } state_t;

    state_t                 state_q;
    logic [NB_DATA-1:0]     word_q;      // word being shifted out, MSB first
    logic [NB_DATA-1:0]     cycles_q;    // cycle count captured at start
    logic [2:0]             cnt_q;       // bytes of the current word still to send
    logic                   tx_start_q;
    logic [7:0]             tx_data_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   reg_rd_en_q;
    logic [NB_REG-1:0]      addr_reg_q;
    logic                   mem_rd_en_q;
    logic [NB_MEM_ADDR-1:0] addr_mem_q;

    logic                   tx_ack_s;
    logic                   last_reg_s;
    logic                   last_mem_s;
    logic [7:0]             addr_byte_s;
    logic [7:0]             end_byte_s;
    state_t                 end_state_s;

    // A done pulse only counts once the start pulse has been seen by the UART.
    assign tx_ack_s    = i_tx_done & ~tx_start_q;
    assign last_reg_s  = (addr_reg_q == {NB_REG{1'b1}});
    assign last_mem_s  = (addr_mem_q == {NB_MEM_ADDR{1'b1}});
    assign addr_byte_s = 8'(addr_mem_q);

`ifdef REPORT_CHECKSUM_EN
    logic [7:0] csum_q;

    assign end_byte_s  = csum_q;
    assign end_state_s = ST_CSUM;

    // Running XOR of each payload byte as it is launched; header, checksum and trailer stay out.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            csum_q <= 8'h00;
        end else if (state_q == ST_IDLE) begin
            csum_q <= 8'h00;
        end else if (tx_start_q && ((state_q == ST_PC) || (state_q == ST_CYC) ||
                                    (state_q == ST_REG_SEND) || (state_q == ST_MEM_SEND))) begin
            csum_q <= csum_q ^ tx_data_q;
        end else begin
            csum_q <= csum_q;
        end
    end
`else
    assign end_byte_s  = TRAILER;
    assign end_state_s = ST_TRL;
`endif

    // Frame sequencer: one byte outstanding at a time, next byte only after the UART acknowledges.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q     <= ST_IDLE;
            word_q      <= '0;
            cycles_q    <= '0;
            cnt_q       <= 3'd0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            reg_rd_en_q <= 1'b0;
            addr_reg_q  <= '0;
            mem_rd_en_q <= 1'b0;
            addr_mem_q  <= '0;
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        word_q     <= i_pc;
                        cycles_q   <= i_cycles;
                        busy_q     <= 1'b1;
                        tx_start_q <= 1'b1;
                        tx_data_q  <= HEADER;
                        state_q    <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (tx_ack_s) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= word_q[NB_DATA-1 -: 8];
                        word_q     <= {word_q[NB_DATA-9:0], 8'h00};
                        cnt_q      <= 3'd3;
                        state_q    <= ST_PC;
                    end
                end
                ST_PC: begin
                    if (tx_ack_s) begin
                        tx_start_q <= 1'b1;
                        if (cnt_q == 3'd0) begin
                            tx_data_q <= cycles_q[NB_DATA-1 -: 8];
                            word_q    <= {cycles_q[NB_DATA-9:0], 8'h00};
                            cnt_q     <= 3'd3;
                            state_q   <= ST_CYC;
                        end else begin
                            tx_data_q <= word_q[NB_DATA-1 -: 8];
                            word_q    <= {word_q[NB_DATA-9:0], 8'h00};
                            cnt_q     <= cnt_q - 3'd1;
                        end
                    end
                end
                ST_CYC: begin
                    if (tx_ack_s) begin
                        if (cnt_q == 3'd0) begin
                            addr_reg_q  <= '0;
                            reg_rd_en_q <= 1'b1;
                            state_q     <= ST_REG_RD;
                        end else begin
                            tx_start_q <= 1'b1;
                            tx_data_q  <= word_q[NB_DATA-1 -: 8];
                            word_q     <= {word_q[NB_DATA-9:0], 8'h00};
                            cnt_q      <= cnt_q - 3'd1;
                        end
                    end
                end
                ST_REG_RD: begin
                    reg_rd_en_q <= 1'b0;
                    state_q     <= ST_REG_LAT;
                end
                ST_REG_LAT: begin
                    tx_start_q <= 1'b1;
                    tx_data_q  <= i_reg_data[NB_DATA-1 -: 8];
                    word_q     <= {i_reg_data[NB_DATA-9:0], 8'h00};
                    cnt_q      <= 3'd3;
                    state_q    <= ST_REG_SEND;
                end
                ST_REG_SEND: begin
                    if (tx_ack_s) begin
                        if (cnt_q != 3'd0) begin
                            tx_start_q <= 1'b1;
                            tx_data_q  <= word_q[NB_DATA-1 -: 8];
                            word_q     <= {word_q[NB_DATA-9:0], 8'h00};
                            cnt_q      <= cnt_q - 3'd1;
                        end else if (last_reg_s) begin
                            addr_mem_q  <= '0;
                            mem_rd_en_q <= 1'b1;
                            state_q     <= ST_MEM_RD;
                        end else begin
                            addr_reg_q  <= addr_reg_q + NB_REG'(1);
                            reg_rd_en_q <= 1'b1;
                            state_q     <= ST_REG_RD;
                        end
                    end
                end
                ST_MEM_RD: begin
                    mem_rd_en_q <= 1'b0;
                    state_q     <= ST_MEM_CHK;
                end
                ST_MEM_CHK: begin
                    if (i_bit_sucio) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= addr_byte_s;
                        word_q     <= i_mem_data;
                        cnt_q      <= 3'd4;
                        state_q    <= ST_MEM_SEND;
                    end else if (last_mem_s) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= end_byte_s;
                        state_q    <= end_state_s;
                    end else begin
                        addr_mem_q  <= addr_mem_q + NB_MEM_ADDR'(1);
                        mem_rd_en_q <= 1'b1;
                        state_q     <= ST_MEM_RD;
                    end
                end
                ST_MEM_SEND: begin
                    if (tx_ack_s) begin
                        if (cnt_q != 3'd0) begin
                            tx_start_q <= 1'b1;
                            tx_data_q  <= word_q[NB_DATA-1 -: 8];
                            word_q     <= {word_q[NB_DATA-9:0], 8'h00};
                            cnt_q      <= cnt_q - 3'd1;
                        end else if (last_mem_s) begin
                            tx_start_q <= 1'b1;
                            tx_data_q  <= end_byte_s;
                            state_q    <= end_state_s;
                        end else begin
                            addr_mem_q  <= addr_mem_q + NB_MEM_ADDR'(1);
                            mem_rd_en_q <= 1'b1;
                            state_q     <= ST_MEM_RD;
                        end
                    end
                end
                ST_CSUM: begin
                    if (tx_ack_s) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= TRAILER;
                        state_q    <= ST_TRL;
                    end
                end
                ST_TRL: begin
                    if (tx_ack_s) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_tx_start  = tx_start_q;
    assign o_tx_data   = tx_data_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_reg_rd_en = reg_rd_en_q;
    assign o_addr_reg  = addr_reg_q;
    assign o_mem_rd_en = mem_rd_en_q;
    assign o_addr_mem  = addr_mem_q;

endmodule

// File: tb/tb_debug_report_tx.sv
// Self-checking bench for debug_report_tx: register file / data memory models
// with one-cycle read latency, a UART responder with random acknowledge delay,
// and a frame-level reference model (byte list plus expected launch spacing).
`timescale 1ns/1ps
module tb_debug_report_tx;
    localparam int NB_DATA     = 32;
    localparam int NB_REG      = 5;
    localparam int NB_MEM_ADDR = 5;
    localparam int MEM_DEPTH   = 2 ** NB_MEM_ADDR;

    logic                   clk = 1'b0;
    logic                   i_reset = 1'b0;
    logic                   i_start = 1'b0;
    logic [NB_DATA-1:0]     i_pc = '0;
    logic [NB_DATA-1:0]     i_cycles = '0;
    logic                   o_reg_rd_en;
    logic [NB_REG-1:0]      o_addr_reg;
    logic [NB_DATA-1:0]     i_reg_data = '0;
    logic                   o_mem_rd_en;
    logic [NB_MEM_ADDR-1:0] o_addr_mem;
    logic [NB_DATA-1:0]     i_mem_data = '0;
    logic                   i_bit_sucio = 1'b0;
    logic                   o_tx_start;
    logic [7:0]             o_tx_data;
    logic                   i_tx_done = 1'b0;
    logic                   o_busy;
    logic                   o_done;

    debug_report_tx dut (
        .i_clock(clk), .i_reset(i_reset), .i_start(i_start), .i_pc(i_pc), .i_cycles(i_cycles),
        .o_reg_rd_en(o_reg_rd_en), .o_addr_reg(o_addr_reg), .i_reg_data(i_reg_data),
        .o_mem_rd_en(o_mem_rd_en), .o_addr_mem(o_addr_mem), .i_mem_data(i_mem_data),
        .i_bit_sucio(i_bit_sucio), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
        .i_tx_done(i_tx_done), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Pipeline-side storage seen through the debug read ports
    logic [31:0] rf  [32];
    logic [31:0] mem [MEM_DEPTH];
    logic        dirty [MEM_DEPTH];

    // Read ports: data for an address appears one cycle after the address
    initial begin : read_ports
        logic [NB_REG-1:0]      ra;
        logic [NB_MEM_ADDR-1:0] ma;
        ra = '0;
        ma = '0;
        forever begin
            @(negedge clk);
            i_reg_data  = rf[ra];
            i_mem_data  = mem[ma];
            i_bit_sucio = dirty[ma];
            ra = o_addr_reg;
            ma = o_addr_mem;
        end
    end

    // UART responder state shared with the main sequence (each variable has one writer)
    int          lat_min = 1;
    int          lat_max = 4;
    int          spur_req = 0;
    int          frame_base = 0;
    int          start_cyc = 0;
    int          done_cnt = 0;
    logic [7:0]  cap_b[$];
    int          cap_g[$];

    initial begin : uart
        bit         outst;
        int         cnt;
        int         spur_sent;
        int         done_cyc;
        logic [7:0] held;
        outst = 1'b0; cnt = 0; spur_sent = 0; done_cyc = 0; held = 8'h00;
        forever begin
            @(negedge clk);
            i_tx_done = 1'b0;
            if (!i_reset) begin
                outst = 1'b0;
            end else begin
                if (o_done) begin
                    done_cnt++;
                    check_eq("busy_low_with_done", o_busy, 32'd0);
                end
                if (outst) begin
                    check_eq("tx_data_hold", o_tx_data, held);
                    check_eq("no_start_while_outstanding", o_tx_start, 32'd0);
                    cnt--;
                    if (cnt <= 0) begin
                        i_tx_done = 1'b1;
                        outst     = 1'b0;
                        done_cyc  = cyc;
                    end
                end else if (o_tx_start) begin
                    cap_g.push_back((cap_b.size() == frame_base) ? cyc - start_cyc : cyc - done_cyc);
                    cap_b.push_back(o_tx_data);
                    held  = o_tx_data;
                    outst = 1'b1;
                    cnt   = $urandom_range(lat_max, lat_min);
                end else if (spur_sent < spur_req) begin
                    i_tx_done = 1'b1;
                    spur_sent++;
                end
            end
        end
    end

    // Reference frame: bytes in order and the cycle distance from the previous
    // acknowledge (or from the start request) to each byte's launch.
    logic [7:0] exp_b[$];
    int         exp_g[$];
    logic [7:0] exp_sum;

    function automatic void put(input logic [7:0] b, input int gap, input bit in_sum);
        exp_b.push_back(b);
        exp_g.push_back(gap);
        if (in_sum) exp_sum = exp_sum ^ b;
    endfunction

    function automatic void put_word(input logic [31:0] w, input int first_gap);
        for (int k = 0; k < 4; k++) put(w[31-8*k -: 8], (k == 0) ? first_gap : 1, 1'b1);
    endfunction

    function automatic void build_expected(input logic [31:0] pc, input logic [31:0] cy);
        int prev;
        exp_b.delete();
        exp_g.delete();
        exp_sum = 8'h00;
        put(8'hA5, 1, 1'b0);
        put_word(pc, 1);
        put_word(cy, 1);
        for (int r = 0; r < 32; r++) put_word(rf[r], 3);   // address, latch, send
        prev = -1;
        for (int a = 0; a < MEM_DEPTH; a++) begin
            if (dirty[a]) begin
                put(8'(a), 1 + 2 * (a - prev), 1'b1);      // 2 cycles per word walked
                put_word(mem[a], 1);
                prev = a;
            end
        end
`ifdef REPORT_CHECKSUM_EN
        put(exp_sum, 1 + 2 * (MEM_DEPTH - 1 - prev), 1'b0);
        put(8'h5A, 1, 1'b0);
`else
        put(8'h5A, 1 + 2 * (MEM_DEPTH - 1 - prev), 1'b0);
`endif
    endfunction

    task automatic pulse_start(input logic [31:0] pc, input logic [31:0] cy);
        @(negedge clk); #1;
        i_pc = pc; i_cycles = cy; i_start = 1'b1; start_cyc = cyc;
        @(negedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic run_frame(input logic [31:0] pc, input logic [31:0] cy, input bit midstart);
        int d0;
        int t;
        build_expected(pc, cy);
        frame_base = cap_b.size();
        d0 = done_cnt;
        pulse_start(pc, cy);
        check_eq("busy_after_start", o_busy, 32'd1);
        if (midstart) begin
            i_pc = ~pc; i_cycles = cy + 32'd77;
            repeat (150) @(negedge clk);
            pulse_start(32'hCAFE0001, 32'h0BAD0002);
        end
        t = 0;
        while (done_cnt == d0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check_eq("frame_completed", (done_cnt > d0) ? 32'd1 : 32'd0, 32'd1);
        repeat (60) @(negedge clk);
        check_eq("done_pulses", done_cnt - d0, 32'd1);
        check_eq("frame_len", cap_b.size() - frame_base, exp_b.size());
        for (int i = 0; i < exp_b.size(); i++) begin
            if (frame_base + i < cap_b.size()) begin
                check_eq($sformatf("byte[%0d]", i), cap_b[frame_base + i], exp_b[i]);
                check_eq($sformatf("gap[%0d]", i), cap_g[frame_base + i], exp_g[i]);
            end
        end
    endtask

    task automatic clear_mem();
        for (int a = 0; a < MEM_DEPTH; a++) begin
            mem[a] = $urandom;
            dirty[a] = 1'b0;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_busy"}, o_busy, 32'd0);
        check_eq({tag, "_tx_start"}, o_tx_start, 32'd0);
        check_eq({tag, "_tx_data"}, o_tx_data, 32'd0);
        check_eq({tag, "_done"}, o_done, 32'd0);
        check_eq({tag, "_reg_rd_en"}, o_reg_rd_en, 32'd0);
        check_eq({tag, "_mem_rd_en"}, o_mem_rd_en, 32'd0);
        check_eq({tag, "_addr_reg"}, o_addr_reg, 32'd0);
        check_eq({tag, "_addr_mem"}, o_addr_mem, 32'd0);
    endtask

    initial begin : main
        int t;
        int sz;
        for (int r = 0; r < 32; r++) rf[r] = 32'(r);
        clear_mem();
        repeat (3) @(negedge clk);
        check_reset_values("por");
        #1 i_reset = 1'b1;

        // Spurious acknowledges while idle must not start anything
        spur_req = 3;
        repeat (10) @(negedge clk);
        check_eq("idle_after_spurious_done", o_busy, 32'd0);
        check_eq("no_bytes_when_idle", cap_b.size(), 32'd0);

        // Registers hold their index, no dirty memory
        run_frame(32'h0000_0010, 32'h0000_002A, 1'b0);

        // Dirty words at 3 and at the last address
        mem[3] = 32'hDEAD_BEEF;            dirty[3] = 1'b1;
        mem[MEM_DEPTH-1] = 32'h1234_5678;  dirty[MEM_DEPTH-1] = 1'b1;
        run_frame(32'h0000_0010, 32'h0000_002A, 1'b0);

        // Re-request and changing PC/cycles mid-frame
        for (int r = 0; r < 32; r++) rf[r] = $urandom;
        run_frame(32'h8765_4321, 32'h0001_0203, 1'b1);

        // Reset during register 7
        build_expected(32'h0000_0010, 32'h0000_002A);
        frame_base = cap_b.size();
        pulse_start(32'h0000_0010, 32'h0000_002A);
        t = 0;
        while (cap_b.size() - frame_base < 38 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check_eq("reached_reg7", (cap_b.size() - frame_base >= 38) ? 32'd1 : 32'd0, 32'd1);
        #1 i_reset = 1'b0;
        @(negedge clk); #1;
        check_reset_values("abort");
        sz = cap_b.size();
        @(negedge clk); #1 i_reset = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("no_tx_after_abort", cap_b.size(), sz);
        run_frame(32'h0000_0010, 32'h0000_002A, 1'b0);

        // Slow UART with spurious acknowledges while idle
        lat_min = 50; lat_max = 50;
        spur_req = spur_req + 2;
        repeat (8) @(negedge clk);
        run_frame(32'h5555_AAAA, 32'h0F0F_F0F0, 1'b0);
        lat_min = 1; lat_max = 6;

        // Checksum-oriented directed frame: PC=1, everything else zero
        for (int r = 0; r < 32; r++) rf[r] = 32'd0;
        clear_mem();
        run_frame(32'h0000_0001, 32'h0000_0000, 1'b0);

        // Random frames
        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < 32; r++) rf[r] = $urandom;
            for (int a = 0; a < MEM_DEPTH; a++) begin
                mem[a] = $urandom;
                dirty[a] = ($urandom_range(3, 0) == 0);
            end
            run_frame($urandom, $urandom, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/debug_report_tx.md
# debug_report_tx

Transmit-side framer of the debug unit: on request it snapshots the program counter and cycle count, walks the register file and the dirty words of data memory, and streams them byte-by-byte to the UART transmitter. It sits between the pipeline's debug read ports and the byte-level UART TX core. It is the return path for the RX/loader path, which assembles incoming bytes into 32-bit instructions.

## Interface
Parameters:
- NB_DATA, 32, data word width; must be 32 (4 bytes per word)
- NB_REG, 5, register address width (32 registers)
- NB_MEM_ADDR, 5, data memory word address width; must be ≤ 8; MEM_DEPTH = 2**NB_MEM_ADDR
- HEADER, 8'hA5, frame start byte
- TRAILER, 8'h5A, frame end byte

Ports:
- i_clock  in  1  single clock, rising edge
- i_reset  in  1  synchronous, active-low reset
- i_start  in  1  one-cycle request to send a report
- i_pc  in  NB_DATA  program counter (pc+1) from pipeline
- i_cycles  in  NB_DATA  executed cycle count
- o_reg_rd_en  out  1  register debug read enable
- o_addr_reg  out  NB_REG  register address
- i_reg_data  in  NB_DATA  register data, valid 1 cycle after address
- o_mem_rd_en  out  1  memory debug read enable
- o_addr_mem  out  NB_MEM_ADDR  memory word address
- i_mem_data  in  NB_DATA  memory data, valid 1 cycle after address
- i_bit_sucio  in  1  dirty flag of addressed word, valid with i_mem_data
- o_tx_start  out  1  one-cycle pulse: load o_tx_data into UART TX
- o_tx_data  out  8  byte to transmit
- i_tx_done  in  1  one-cycle pulse: UART TX finished current byte
- o_busy  out  1  frame in progress
- o_done  out  1  one-cycle pulse after trailer's i_tx_done

## Operation
- Frame: HEADER, PC[31:0] (4 bytes, MSB first), CYCLES (4 bytes, MSB first), R0..R31 (4 bytes each, MSB first), then for each dirty memory word in ascending address: address byte (zero-extended) + 4 data bytes MSB first, then [checksum], TRAILER.
- i_pc and i_cycles are captured on the cycle i_start is accepted; later changes do not affect the frame.
- i_start accepted only in IDLE; ignored while o_busy=1.
- States: IDLE → HDR → PC → CYC → REG_RD → REG_SEND → (next reg or MEM_RD) → MEM_RD → MEM_CHK → MEM_SEND or next address → CSUM (if enabled) → TRL → IDLE.
- REG_RD: drive o_addr_reg, o_reg_rd_en=1; latch i_reg_data next cycle into 32-bit shift register.
- MEM_CHK: i_bit_sucio=0 → skip to next address with no bytes sent; 1 → send address + data.
- Memory walk ends after address MEM_DEPTH-1; address counter does not wrap to revisit 0.
- Every byte uses the same handshake: o_tx_start pulse with o_tx_data stable until i_tx_done; next byte only after i_tx_done.
- Reset (i_reset=0) at any time: abort frame, return to IDLE, no further o_tx_start.

## Timing
- Reset values: o_tx_start=0, o_tx_data=0, o_busy=0, o_done=0, o_reg_rd_en=0, o_mem_rd_en=0, o_addr_reg=0, o_addr_mem=0.
- i_start sampled at cycle N → o_busy=1 and o_tx_start=1 (HEADER) at cycle N+1.
- i_tx_done at cycle M → next o_tx_start no earlier than M+1; at M+1 when next byte is in a held word, at M+3 when a fresh read is needed (address, data latch, send).
- i_tx_done in the same cycle as o_tx_start, or while no byte is outstanding, is ignored.
- o_tx_data held constant from o_tx_start until the matching i_tx_done.
- Clean memory word costs 2 cycles (address, check), no bytes.
- o_done pulses the cycle after the trailer's i_tx_done; o_busy falls the same cycle.
- Frame length: 138 + 5·(dirty words) bytes, +1 with checksum.

## Configuration
- REPORT_CHECKSUM_EN defined: one byte inserted before TRAILER = XOR of all bytes from first PC byte through last memory byte (HEADER excluded); frame length +1.
- Undefined: no checksum byte, no checksum register; TRAILER follows last memory/register byte directly.

## Test plan
- No dirty words, i_pc=0x00000010, i_cycles=0x0000002A, Rk=k: bytes A5,00,00,00,10,00,00,00,2A,then 00,00,00,00 … 00,00,00,1F, 5A; 138 bytes, one o_done.
- Dirty at addresses 3 (0xDEADBEEF) and MEM_DEPTH-1 (0x12345678): after R31 sends 03,DE,AD,BE,EF,1F,12,34,56,78,5A; no byte for clean addresses.
- i_start pulsed again mid-frame and i_pc changed after start: frame unchanged, single o_done.
- i_reset=0 during register 7 transmission: next cycle o_busy=0, o_tx_start=0, all outputs at reset values; new i_start yields a full frame from HEADER.
- UART slow (i_tx_done 50 cycles after each start) and spurious i_tx_done while idle: o_tx_data stable through each byte, no skipped or duplicated bytes.
- REPORT_CHECKSUM_EN with only PC=0x01, cycles=0, all regs 0, no dirty: checksum byte 01 before 5A, 139 bytes.
